pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, the width of PC and immediate.
REQ-002 SHALL have parameter REG_INDEX_BIT_WIDTH, default 4, the register index width.
REQ-003 SHALL have parameter ALU_OP_WIDTH, default 5, the ALU opcode width.
REQ-004 SHALL have parameter ALU_MUX_WIDTH, default 2, the ALU operand-select width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all held entries (branch mispredict or exception).
REQ-008 SHALL have port in_valid, input, 1 bit: the upstream stage presents a decoded instruction.
REQ-009 SHALL have port in_ready, output, 1 bit: this block can accept the instruction this cycle.
REQ-010 SHALL have input fields: pc_in (BIT_WIDTH), imm_in (BIT_WIDTH), src1_in, src2_in and dst_ind_in (REG_INDEX_BIT_WIDTH each), alu_op_in (ALU_OP_WIDTH), alu_mux_in (ALU_MUX_WIDTH), and mem_wrt_en_in and reg_file_wrt_en_in (1 bit each).
REQ-011 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the execute stage consumes the head this cycle.
REQ-013 SHALL have output fields named like the inputs with the _out suffix replacing _in, each of the same width.
REQ-014 SHALL have port occupancy, output, 2 bits: the number of valid entries held (0..2).

Function
REQ-015 SHALL hold two entries, main (head) and skid; all outputs are registered.
REQ-016 SHALL drive in_ready = NOT skid_valid, registered, with no combinational path from out_ready.
REQ-017 SHALL define accept as in_valid AND in_ready AND NOT flush, and pop as out_valid AND out_ready.
REQ-018 SHALL, on accept with main empty (or popping) and skid empty, load main the next cycle; in-to-out latency is 1 cycle.
REQ-019 SHALL, on accept with main valid and no pop, load skid; in_ready falls the next cycle.
REQ-020 SHALL, on pop with skid valid, move skid to main the next cycle; in_ready rises that cycle.
REQ-021 SHALL never have skid valid while main is invalid.
REQ-022 SHALL treat accept with pop on a full main and empty skid as a replace: the new entry goes to main and skid stays empty.
REQ-023 SHALL, on flush, clear both valids the next cycle; flush beats a simultaneous accept (dropped) and pop (still counted as consumed by the downstream stage).
REQ-024 SHALL gate mem_wrt_en_out and reg_file_wrt_en_out with out_valid, so a bubble never writes.
REQ-025 SHALL leave the other data outputs holding their last value while out_valid = 0.
REQ-026 SHALL make occupancy equal main_valid + skid_valid at all times.
REQ-027 SHALL drop in_valid when in_ready = 0, with no state change; upstream holds its data.

Reset
REQ-028 SHALL, when reset = 1 at a clock edge, zero all entries and valids: out_valid = 0, occupancy = 0, in_ready = 1 and every data output 0.
REQ-029 SHALL give reset priority over flush, accept and pop; a reset mid-stall discards both entries.

Structure
REQ-030 SHALL place the default widths and the packed payload width (2*BIT_WIDTH + 3*REG_INDEX_BIT_WIDTH + ALU_OP_WIDTH + ALU_MUX_WIDTH + 2) as shared constants in the common pipeline header/package, pipe_pkg.
REQ-031 SHALL pack the fields into one payload vector internally.
REQ-032 SHALL use the existing Register sub-module (clk, reset, en, d, q) at payload width for each of main and skid, plus 1-bit Register instances for the valids.

Verification
REQ-033 Reset and single pass: reset 1 cycle, then in_valid = 1 with pc_in = 0x100 and out_ready = 1 -> next cycle out_valid = 1, pc_out = 0x100, occupancy = 1.
REQ-034 Stall fill: out_ready = 0, send pc 0x10 then 0x14 -> occupancy = 2, in_ready = 0, and a third instruction 0x18 is not accepted.
REQ-035 Drain order: from REQ-034, raise out_ready -> pc_out is 0x10 then 0x14, in_ready = 1 one cycle after the first pop.
REQ-036 Flush: occupancy = 2 plus flush with in_valid = 1 (pc 0x20) -> next cycle out_valid = 0, occupancy = 0, mem_wrt_en_out = 0, and 0x20 never appears.
REQ-037 Bubble gating: accept reg_file_wrt_en_in = 1, pop it, in_valid = 0 -> reg_file_wrt_en_out = 0 while out_valid = 0.
REQ-038 Reset mid-stall: occupancy = 2, assert reset together with flush -> all outputs 0 and in_ready = 1 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default field widths and the packed payload width.
package pipe_pkg;

  localparam int unsigned DefBitWidth         = 32;
  localparam int unsigned DefRegIndexBitWidth = 4;
  localparam int unsigned DefAluOpWidth       = 5;
  localparam int unsigned DefAluMuxWidth      = 2;

  // pc + imm, three register indices, ALU op/select, two write enables.
  function automatic int unsigned payload_width(input int unsigned bw, input int unsigned rw,
                                                input int unsigned ow, input int unsigned mw);
    return 2 * bw + 3 * rw + ow + mw + 2;
  endfunction

  localparam int unsigned PayloadWidth =
      payload_width(DefBitWidth, DefRegIndexBitWidth, DefAluOpWidth, DefAluMuxWidth);

endpackage

// File: rtl/Register.sv
// Generic enabled register with synchronous active-high clear.
module Register #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Two-entry (main + skid) pipeline buffer between decode and execute with flush.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned BIT_WIDTH           = DefBitWidth,
  parameter int unsigned REG_INDEX_BIT_WIDTH = DefRegIndexBitWidth,
  parameter int unsigned ALU_OP_WIDTH        = DefAluOpWidth,
  parameter int unsigned ALU_MUX_WIDTH       = DefAluMuxWidth
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIT_WIDTH-1:0]           pc_in,
  input  logic [BIT_WIDTH-1:0]           imm_in,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] src1_in,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] src2_in,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_in,
  input  logic [ALU_OP_WIDTH-1:0]        alu_op_in,
  input  logic [ALU_MUX_WIDTH-1:0]       alu_mux_in,
  input  logic                           mem_wrt_en_in,
  input  logic                           reg_file_wrt_en_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BIT_WIDTH-1:0]           pc_out,
  output logic [BIT_WIDTH-1:0]           imm_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] src1_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] src2_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_out,
  output logic [ALU_OP_WIDTH-1:0]        alu_op_out,
  output logic [ALU_MUX_WIDTH-1:0]       alu_mux_out,
  output logic                           mem_wrt_en_out,
  output logic                           reg_file_wrt_en_out,
  output logic [1:0]                     occupancy
);

  localparam int unsigned PW =
      payload_width(BIT_WIDTH, REG_INDEX_BIT_WIDTH, ALU_OP_WIDTH, ALU_MUX_WIDTH);

  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic [PW-1:0] w_main_d;
  logic          r_main_v;
  logic          r_skid_v;
  logic          w_main_v_d;
  logic          w_skid_v_d;
  logic          w_main_en;
  logic          w_skid_en;
  logic          w_accept;
  logic          w_pop;
  logic          w_mem_wrt;
  logic          w_reg_wrt;

  assign w_in_payload = {pc_in, imm_in, src1_in, src2_in, dst_ind_in, alu_op_in, alu_mux_in,
                         mem_wrt_en_in, reg_file_wrt_en_in};

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_pop     = r_main_v & out_ready;

  always_comb begin
    w_main_d   = w_in_payload;
    w_main_en  = 1'b0;
    w_skid_en  = 1'b0;
    w_main_v_d = r_main_v;
    w_skid_v_d = r_skid_v;
    if (flush) begin
      // Data registers hold so the outputs keep their last value while invalid.
      w_main_v_d = 1'b0;
      w_skid_v_d = 1'b0;
    end else if (w_pop && r_skid_v) begin
      w_main_d   = r_skid;
      w_main_en  = 1'b1;
      w_main_v_d = 1'b1;
      w_skid_v_d = 1'b0;
    end else if (w_accept && (!r_main_v || w_pop)) begin
      w_main_en  = 1'b1;
      w_main_v_d = 1'b1;
    end else if (w_accept) begin
      w_skid_en  = 1'b1;
      w_skid_v_d = 1'b1;
    end else if (w_pop) begin
      w_main_v_d = 1'b0;
    end
  end

  Register #(.WIDTH(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (w_main_en),
    .d     (w_main_d),
    .q     (r_main)
  );

  Register #(.WIDTH(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (w_skid_en),
    .d     (w_in_payload),
    .q     (r_skid)
  );

  Register #(.WIDTH(1)) u_main_v (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (w_main_v_d),
    .q     (r_main_v)
  );

  Register #(.WIDTH(1)) u_skid_v (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (w_skid_v_d),
    .q     (r_skid_v)
  );

  assign {pc_out, imm_out, src1_out, src2_out, dst_ind_out, alu_op_out, alu_mux_out,
          w_mem_wrt, w_reg_wrt} = r_main;

  assign mem_wrt_en_out      = w_mem_wrt & r_main_v;
  assign reg_file_wrt_en_out = w_reg_wrt & r_main_v;
  assign occupancy           = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed vector table plus hand sequences for the main/skid pipeline buffer.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pc_in, imm_in, pc_out, imm_out;
  logic [3:0]  src1_in, src2_in, dst_ind_in, src1_out, src2_out, dst_ind_out;
  logic [4:0]  alu_op_in, alu_op_out;
  logic [1:0]  alu_mux_in, alu_mux_out, occupancy;
  logic        mem_wrt_en_in, reg_file_wrt_en_in, mem_wrt_en_out, reg_file_wrt_en_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer u_dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .pc_in               (pc_in),
    .imm_in              (imm_in),
    .src1_in             (src1_in),
    .src2_in             (src2_in),
    .dst_ind_in          (dst_ind_in),
    .alu_op_in           (alu_op_in),
    .alu_mux_in          (alu_mux_in),
    .mem_wrt_en_in       (mem_wrt_en_in),
    .reg_file_wrt_en_in  (reg_file_wrt_en_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .pc_out              (pc_out),
    .imm_out             (imm_out),
    .src1_out            (src1_out),
    .src2_out            (src2_out),
    .dst_ind_out         (dst_ind_out),
    .alu_op_out          (alu_op_out),
    .alu_mux_out         (alu_mux_out),
    .mem_wrt_en_out      (mem_wrt_en_out),
    .reg_file_wrt_en_out (reg_file_wrt_en_out),
    .occupancy           (occupancy)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        mw;
    logic        rw;
    logic        ov;
    logic [31:0] epc;
    logic [1:0]  occ;
    logic        ir;
    logic        mwo;
    logic        rwo;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [31:0] imm_of(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : (pc ^ 32'hA5A5_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [31:0] pc,
                       input logic ordy, input logic mw, input logic rw);
    reset              = rst;
    flush              = fl;
    in_valid           = iv;
    pc_in              = pc;
    imm_in             = imm_of(pc);
    out_ready          = ordy;
    mem_wrt_en_in      = mw;
    reg_file_wrt_en_in = rw;
    src1_in            = 4'h1;
    src2_in            = 4'h2;
    dst_ind_in         = 4'h3;
    alu_op_in          = 5'h04;
    alu_mux_in         = 2'h1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst fl iv pc ordy mw rw | ov epc occ ir mwo rwo (state after the edge)
    vecs[0]  = '{1, 0, 0, 32'h000, 0, 0, 0, 0, 32'h000, 2'd0, 1, 0, 0};
    vecs[1]  = '{0, 0, 1, 32'h100, 1, 1, 1, 1, 32'h100, 2'd1, 1, 1, 1};
    vecs[2]  = '{0, 0, 0, 32'h000, 1, 0, 0, 0, 32'h100, 2'd0, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 32'h010, 0, 0, 1, 1, 32'h010, 2'd1, 1, 0, 1};
    vecs[4]  = '{0, 0, 1, 32'h014, 0, 1, 0, 1, 32'h010, 2'd2, 0, 0, 1};
    vecs[5]  = '{0, 0, 1, 32'h018, 0, 0, 0, 1, 32'h010, 2'd2, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 32'h000, 1, 0, 0, 1, 32'h014, 2'd1, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 32'h000, 1, 0, 0, 0, 32'h014, 2'd0, 1, 0, 0};
    vecs[8]  = '{0, 0, 1, 32'h030, 0, 0, 0, 1, 32'h030, 2'd1, 1, 0, 0};
    vecs[9]  = '{0, 0, 1, 32'h034, 1, 0, 0, 1, 32'h034, 2'd1, 1, 0, 0};
    vecs[10] = '{0, 0, 1, 32'h040, 0, 0, 0, 1, 32'h034, 2'd2, 0, 0, 0};
    vecs[11] = '{0, 1, 1, 32'h020, 0, 1, 0, 0, 32'h034, 2'd0, 1, 0, 0};
    vecs[12] = '{0, 1, 1, 32'h050, 0, 1, 1, 0, 32'h034, 2'd0, 1, 0, 0};
    vecs[13] = '{0, 0, 1, 32'h060, 0, 1, 1, 1, 32'h060, 2'd1, 1, 1, 1};
    vecs[14] = '{0, 0, 1, 32'h064, 0, 0, 0, 1, 32'h060, 2'd2, 0, 1, 1};
    vecs[15] = '{1, 1, 1, 32'h070, 1, 1, 1, 0, 32'h000, 2'd0, 1, 0, 0};
    vecs[16] = '{0, 0, 1, 32'h080, 0, 0, 0, 1, 32'h080, 2'd1, 1, 0, 0};

    drive(1, 0, 0, 32'h0, 0, 0, 0);
    step();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].mw,
            vecs[i].rw);
      step();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d pc_out", i), pc_out, vecs[i].epc);
      chk($sformatf("v%0d imm_out", i), imm_out, imm_of(vecs[i].epc));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d mem_wrt_en_out", i), 32'(mem_wrt_en_out), 32'(vecs[i].mwo));
      chk($sformatf("v%0d reg_wrt_en_out", i), 32'(reg_file_wrt_en_out), 32'(vecs[i].rwo));
    end

    // Reset with everything else zero: all data fields must read zero.
    drive(1, 0, 0, 32'h0, 0, 0, 0);
    step();
    chk("rst src1_out", 32'(src1_out), 32'h0);
    chk("rst dst_ind_out", 32'(dst_ind_out), 32'h0);
    chk("rst alu_op_out", 32'(alu_op_out), 32'h0);

    // All fields pass through with distinct values.
    drive(0, 0, 1, 32'h200, 0, 1, 0);
    src1_in    = 4'h9;
    src2_in    = 4'hA;
    dst_ind_in = 4'hB;
    alu_op_in  = 5'h1C;
    alu_mux_in = 2'h3;
    step();
    chk("fields src1_out", 32'(src1_out), 32'h9);
    chk("fields src2_out", 32'(src2_out), 32'hA);
    chk("fields dst_ind_out", 32'(dst_ind_out), 32'hB);
    chk("fields alu_op_out", 32'(alu_op_out), 32'h1C);
    chk("fields alu_mux_out", 32'(alu_mux_out), 32'h3);
    chk("fields mem_wrt_en_out", 32'(mem_wrt_en_out), 32'h1);

    // Streaming back-to-back with out_ready high: one per cycle, never stalls.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 32'h300 + 32'(4 * k), 1, 0, 1);
      step();
      chk($sformatf("stream%0d pc_out", k), pc_out, 32'h300 + 32'(4 * k));
      chk($sformatf("stream%0d occupancy", k), 32'(occupancy), 32'd1);
      chk($sformatf("stream%0d in_ready", k), 32'(in_ready), 32'd1);
    end

    // Flush together with pop and accept: entry dropped, buffer empty.
    drive(0, 1, 1, 32'h400, 1, 1, 1);
    step();
    chk("flush+pop out_valid", 32'(out_valid), 32'h0);
    chk("flush+pop occupancy", 32'(occupancy), 32'h0);
    chk("flush+pop pc_out held", pc_out, 32'h308);
    drive(0, 0, 0, 32'h0, 1, 0, 0);
    step();
    chk("after flush out_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
